// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared constants for the main-memory arbiter: FSM state
//               encoding, requester side identifiers and the cache block
//               length in words (the same value Cache_Control uses).
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Arbiter FSM state encoding
    localparam logic [1:0] ARB_IDLE    = 2'd0;
    localparam logic [1:0] ARB_GRANT_I = 2'd1;
    localparam logic [1:0] ARB_GRANT_D = 2'd2;
    localparam logic [1:0] ARB_DONE    = 2'd3;

    // Identifies which side most recently completed a fill
    localparam logic C_SIDE_I = 1'b0;
    localparam logic C_SIDE_D = 1'b1;

    // Words per cache block; shared with Cache_Control
    localparam int WORDS_PER_BLOCK = 8;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/beat_counter.sv
`default_nettype none
// ============================================================================
// Module      : beat_counter
// Description : Counts valid DRAM beats within one block fill and flags the
//               final beat of the block.
// Ports       : clk  - system clock
//               rst  - asynchronous active-high reset
//               clr  - synchronous clear (has priority over inc)
//               inc  - advance the count by one
//               last - count currently equals WORDS_PER_BLOCK-1
// Revision    : 1.0 - initial release
// ============================================================================
module beat_counter #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int CNT_W           = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic last
);

    localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(WORDS_PER_BLOCK - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign last = (r_count == C_LAST_CNT);

endmodule : beat_counter
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Arbitrates the single off-chip memory port between the
//               instruction-side and data-side memory_system instances.
//               One requester is granted at a time; the grant is held until a
//               full block has returned, followed by a one-cycle dead state.
//               Ties are broken away from the side that last completed.
// Ports       : clk            - system clock
//               rst            - asynchronous active-high reset
//               i_busy/i_addr  - I-side miss pending / fill address
//               d_busy/d_addr  - D-side miss pending / fill address
//               mem_data_valid - DRAM returning a valid word
//               i_proceed      - grant to I-side
//               d_proceed      - grant to D-side
//               i_data_valid   - mem_data_valid gated to I-side
//               d_data_valid   - mem_data_valid gated to D-side
//               mem_enable     - DRAM read enable
//               mem_addr       - DRAM address (0 when not granting)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int WORDS_PER_BLOCK = mem_arb_pkg::WORDS_PER_BLOCK,
    parameter int CNT_W           = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_busy,
    input  logic [15:0] i_addr,
    input  logic        d_busy,
    input  logic [15:0] d_addr,
    input  logic        mem_data_valid,
    output logic        i_proceed,
    output logic        d_proceed,
    output logic        i_data_valid,
    output logic        d_data_valid,
    output logic        mem_enable,
    output logic [15:0] mem_addr
);

    import mem_arb_pkg::*;

    logic [1:0] r_state;
    logic       r_last_grant;

    logic w_grant_i;
    logic w_grant_d;
    logic w_granted;
    logic w_owner_busy;
    logic w_last;
    logic w_final;
    logic w_abort;
    logic w_cnt_clr;
    logic w_cnt_inc;

    assign w_grant_i    = (r_state == ARB_GRANT_I);
    assign w_grant_d    = (r_state == ARB_GRANT_D);
    assign w_granted    = w_grant_i | w_grant_d;
    assign w_owner_busy = w_grant_i ? i_busy : d_busy;

    // Completing the block takes precedence over a busy drop on the same beat
    assign w_final = w_granted & mem_data_valid & w_last;
    assign w_abort = w_granted & ~w_owner_busy & ~w_final;

    // Held clear outside a grant so stray beats in IDLE/DONE are never counted
    assign w_cnt_clr = ~w_granted | w_final | w_abort;
    assign w_cnt_inc = w_granted & mem_data_valid;

    beat_counter #(
        .WORDS_PER_BLOCK (WORDS_PER_BLOCK),
        .CNT_W           (CNT_W)
    ) u_beat_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_cnt_clr),
        .inc  (w_cnt_inc),
        .last (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ARB_IDLE;
            r_last_grant <= C_SIDE_I;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (i_busy && d_busy) begin
                        // Grant the side that did not finish most recently
                        r_state <= (r_last_grant == C_SIDE_I) ? ARB_GRANT_D : ARB_GRANT_I;
                    end else if (i_busy) begin
                        r_state <= ARB_GRANT_I;
                    end else if (d_busy) begin
                        r_state <= ARB_GRANT_D;
                    end
                end
                ARB_GRANT_I: begin
                    if (w_final) begin
                        r_state      <= ARB_DONE;
                        r_last_grant <= C_SIDE_I;
                    end else if (w_abort) begin
                        r_state <= ARB_IDLE;
                    end
                end
                ARB_GRANT_D: begin
                    if (w_final) begin
                        r_state      <= ARB_DONE;
                        r_last_grant <= C_SIDE_D;
                    end else if (w_abort) begin
                        r_state <= ARB_IDLE;
                    end
                end
                // Dead cycle lets the finished requester drop fsm_busy
                ARB_DONE: begin
                    r_state <= ARB_IDLE;
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign i_proceed    = w_grant_i;
    assign d_proceed    = w_grant_d;
    assign mem_enable   = w_granted;
    assign i_data_valid = w_grant_i & mem_data_valid;
    assign d_data_valid = w_grant_d & mem_data_valid;
    assign mem_addr     = w_grant_i ? i_addr :
                          w_grant_d ? d_addr : 16'h0000;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter. Inputs change
//               1 time unit after a rising edge; outputs are checked 1 time
//               unit later, well away from the next edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_busy;
    logic [15:0] i_addr;
    logic        d_busy;
    logic [15:0] d_addr;
    logic        mem_data_valid;
    logic        i_proceed;
    logic        d_proceed;
    logic        i_data_valid;
    logic        d_data_valid;
    logic        mem_enable;
    logic [15:0] mem_addr;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(
        .WORDS_PER_BLOCK (8),
        .CNT_W           (3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_busy         (i_busy),
        .i_addr         (i_addr),
        .d_busy         (d_busy),
        .d_addr         (d_addr),
        .mem_data_valid (mem_data_valid),
        .i_proceed      (i_proceed),
        .d_proceed      (d_proceed),
        .i_data_valid   (i_data_valid),
        .d_data_valid   (d_data_valid),
        .mem_enable     (mem_enable),
        .mem_addr       (mem_addr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus only: drive one DRAM beat through a clock edge
    task automatic beat();
        mem_data_valid = 1'b1;
        tick();
        mem_data_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        i_busy         = 1'b0;
        d_busy         = 1'b0;
        i_addr         = 16'h0;
        d_addr         = 16'h0;
        mem_data_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        i_busy         = 1'b1;
        d_busy         = 1'b1;
        i_addr         = 16'hAAAA;
        d_addr         = 16'h5555;
        mem_data_valid = 1'b1;
        tick();
        #1;
        checks++;
        if ({i_proceed, d_proceed, mem_enable, i_data_valid, d_data_valid} !== 5'b00000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {i_proceed, d_proceed, mem_enable, i_data_valid, d_data_valid});
        end
        checks++;
        if (mem_addr !== 16'h0000) begin
            failures++;
            $display("FAIL reset_addr: got %h expected 0000", mem_addr);
        end
        do_reset();
    endtask

    task automatic test_single_i();
        i_addr = 16'h0040;
        d_addr = 16'h1234;
        i_busy = 1'b1;
        #1;
        checks++;
        if (i_proceed !== 1'b0) begin
            failures++;
            $display("FAIL single_latency: i_proceed got %b expected 0", i_proceed);
        end
        tick();
        checks++;
        if ({i_proceed, d_proceed, mem_enable} !== 3'b101 || mem_addr !== 16'h0040) begin
            failures++;
            $display("FAIL single_grant: ctrl %b addr %h expected 101 addr 0040",
                     {i_proceed, d_proceed, mem_enable}, mem_addr);
        end
        for (int k = 0; k < 8; k++) begin
            if (k == 3) begin
                // Idle gap mid-fill: nothing forwarded
                mem_data_valid = 1'b0;
                #1;
                checks++;
                if ({i_data_valid, d_data_valid, i_proceed} !== 3'b001) begin
                    failures++;
                    $display("FAIL single_gap: dv_i/dv_d/proc got %b expected 001",
                             {i_data_valid, d_data_valid, i_proceed});
                end
                tick();
            end
            mem_data_valid = 1'b1;
            #1;
            checks++;
            if ({i_data_valid, d_data_valid, i_proceed} !== 3'b101) begin
                failures++;
                $display("FAIL single_beat%0d: dv_i/dv_d/proc got %b expected 101",
                         k, {i_data_valid, d_data_valid, i_proceed});
            end
            tick();
        end
        mem_data_valid = 1'b0;
        i_busy         = 1'b0;
        #1;
        checks++;
        if ({i_proceed, d_proceed, mem_enable} !== 3'b000 || mem_addr !== 16'h0000) begin
            failures++;
            $display("FAIL single_end: ctrl %b addr %h expected 000 addr 0000",
                     {i_proceed, d_proceed, mem_enable}, mem_addr);
        end
        tick();
        tick();
    endtask

    task automatic test_simultaneous();
        do_reset();
        i_addr = 16'h0100;
        d_addr = 16'h0200;
        i_busy = 1'b1;
        d_busy = 1'b1;
        tick();
        #1;
        checks++;
        if ({i_proceed, d_proceed} !== 2'b01 || mem_addr !== 16'h0200) begin
            failures++;
            $display("FAIL tie_first: proc_i/proc_d %b addr %h expected 01 addr 0200",
                     {i_proceed, d_proceed}, mem_addr);
        end
        for (int k = 0; k < 8; k++) begin
            mem_data_valid = 1'b1;
            #1;
            checks++;
            if ({i_data_valid, d_data_valid} !== 2'b01) begin
                failures++;
                $display("FAIL tie_beat%0d: dv_i/dv_d got %b expected 01",
                         k, {i_data_valid, d_data_valid});
            end
            tick();
        end
        mem_data_valid = 1'b0;
        d_busy         = 1'b0;
        #1;
        checks++;
        if ({i_proceed, d_proceed, mem_enable} !== 3'b000) begin
            failures++;
            $display("FAIL tie_done: ctrl %b expected 000", {i_proceed, d_proceed, mem_enable});
        end
        tick();
        checks++;
        if ({i_proceed, d_proceed} !== 2'b00) begin
            failures++;
            $display("FAIL tie_idle: proc_i/proc_d %b expected 00", {i_proceed, d_proceed});
        end
        tick();
        checks++;
        if ({i_proceed, d_proceed} !== 2'b10 || mem_addr !== 16'h0100) begin
            failures++;
            $display("FAIL tie_second: proc_i/proc_d %b addr %h expected 10 addr 0100",
                     {i_proceed, d_proceed}, mem_addr);
        end
        for (int k = 0; k < 8; k++) beat();
        i_busy = 1'b0;
        tick();
    endtask

    task automatic test_during_fill();
        i_addr = 16'h0300;
        d_addr = 16'h0400;
        i_busy = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            if (k == 3) d_busy = 1'b1;
            mem_data_valid = 1'b1;
            #1;
            checks++;
            if ({i_proceed, d_proceed} !== 2'b10 || mem_addr !== 16'h0300) begin
                failures++;
                $display("FAIL fill_hold%0d: proc_i/proc_d %b addr %h expected 10 addr 0300",
                         k, {i_proceed, d_proceed}, mem_addr);
            end
            tick();
        end
        mem_data_valid = 1'b0;
        i_busy         = 1'b0;
        #1;
        checks++;
        if (d_proceed !== 1'b0) begin
            failures++;
            $display("FAIL fill_t1: d_proceed got %b expected 0", d_proceed);
        end
        tick();
        checks++;
        if (d_proceed !== 1'b0) begin
            failures++;
            $display("FAIL fill_t2: d_proceed got %b expected 0", d_proceed);
        end
        tick();
        checks++;
        if (d_proceed !== 1'b1 || mem_addr !== 16'h0400) begin
            failures++;
            $display("FAIL fill_t3: d_proceed %b addr %h expected 1 addr 0400", d_proceed, mem_addr);
        end
        for (int k = 0; k < 8; k++) beat();
        d_busy = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        i_addr = 16'h0500;
        i_busy = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) beat();
        i_busy = 1'b0;
        tick();
        checks++;
        if ({i_proceed, mem_enable} !== 2'b00) begin
            failures++;
            $display("FAIL abort_idle: proc/en got %b expected 00", {i_proceed, mem_enable});
        end
        mem_data_valid = 1'b1;
        #1;
        checks++;
        if ({i_data_valid, d_data_valid} !== 2'b00) begin
            failures++;
            $display("FAIL abort_stray: dv_i/dv_d got %b expected 00", {i_data_valid, d_data_valid});
        end
        tick();
        mem_data_valid = 1'b0;
        i_busy         = 1'b1;
        tick();
        // Counter must have restarted at zero: a full 8 beats are needed
        for (int k = 0; k < 7; k++) begin
            mem_data_valid = 1'b1;
            #1;
            checks++;
            if (i_proceed !== 1'b1) begin
                failures++;
                $display("FAIL abort_regrant%0d: i_proceed got %b expected 1", k, i_proceed);
            end
            tick();
        end
        beat();
        i_busy = 1'b0;
        #1;
        checks++;
        if (i_proceed !== 1'b0) begin
            failures++;
            $display("FAIL abort_complete: i_proceed got %b expected 0", i_proceed);
        end
        tick();
    endtask

    task automatic test_reset_mid_fill();
        d_addr = 16'h0600;
        d_busy = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) beat();
        mem_data_valid = 1'b1;
        #1;
        checks++;
        if (d_data_valid !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre: d_data_valid got %b expected 1", d_data_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({i_proceed, d_proceed, mem_enable, i_data_valid, d_data_valid} !== 5'b00000 ||
            mem_addr !== 16'h0000) begin
            failures++;
            $display("FAIL rstmid_async: ctrl %b addr %h expected 00000 addr 0000",
                     {i_proceed, d_proceed, mem_enable, i_data_valid, d_data_valid}, mem_addr);
        end
        @(negedge clk);
        rst            = 1'b0;
        mem_data_valid = 1'b0;
        tick();
        for (int k = 0; k < 7; k++) begin
            mem_data_valid = 1'b1;
            #1;
            checks++;
            if (d_proceed !== 1'b1) begin
                failures++;
                $display("FAIL rstmid_beat%0d: d_proceed got %b expected 1", k, d_proceed);
            end
            tick();
        end
        beat();
        d_busy = 1'b0;
        #1;
        checks++;
        if (d_proceed !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_complete: d_proceed got %b expected 0", d_proceed);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        i_addr = 16'h0700;
        i_busy = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) beat();
        #1;
        checks++;
        if (i_proceed !== 1'b0) begin
            failures++;
            $display("FAIL b2b_done: i_proceed got %b expected 0", i_proceed);
        end
        tick();
        checks++;
        if (i_proceed !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle: i_proceed got %b expected 0", i_proceed);
        end
        tick();
        checks++;
        if (i_proceed !== 1'b1 || mem_addr !== 16'h0700) begin
            failures++;
            $display("FAIL b2b_regrant: i_proceed %b addr %h expected 1 addr 0700", i_proceed, mem_addr);
        end
        i_busy = 1'b0;
        tick();
        checks++;
        if (i_proceed !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drop: i_proceed got %b expected 0", i_proceed);
        end
        tick();
        checks++;
        if ({i_proceed, d_proceed} !== 2'b00) begin
            failures++;
            $display("FAIL b2b_quiet: proc_i/proc_d got %b expected 00", {i_proceed, d_proceed});
        end
    endtask

    initial begin
        test_reset();
        test_single_i();
        test_simultaneous();
        test_during_fill();
        test_abort();
        test_reset_mid_fill();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire
